// File: rtl/logic_gate_unit.sv
// Pipelined bitwise logic unit (AND/OR/XOR/NAND/NOR/XNOR/PASS/NOT) with a valid/ready output register.
// Optional truth-table sweep engine compiled in only when LOGIC_GATE_SWEEP_EN is defined.
module logic_gate_unit #(
    parameter int WIDTH  = 4,
    parameter int NUM_IN = 2
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic [2:0]              MODE,
    input  logic [NUM_IN*WIDTH-1:0] A,
    input  logic                    IN_VALID,
    output logic                    IN_READY,
    output logic [WIDTH-1:0]        Q,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY,
    input  logic                    SWEEP_START,
    output logic                    SWEEP_BUSY,
    output logic                    SWEEP_DONE,
    output logic [2**NUM_IN-1:0]    TT
);

    // Each result bit j reduces bit j of every operand; modes 6/7 look at operand 0 only.
    function automatic logic [WIDTH-1:0] evalOp(input logic [2:0] op,
                                                input logic [NUM_IN*WIDTH-1:0] ops);
        logic [WIDTH-1:0] res;
        logic             andR;
        logic             orR;
        logic             xorR;
        res = '0;
        for (int j = 0; j < WIDTH; j++) begin
            andR = 1'b1;
            orR  = 1'b0;
            xorR = 1'b0;
            for (int k = 0; k < NUM_IN; k++) begin
                andR = andR & ops[k*WIDTH+j];
                orR  = orR  | ops[k*WIDTH+j];
                xorR = xorR ^ ops[k*WIDTH+j];
            end
            case (op)
                3'd0:    res[j] = andR;
                3'd1:    res[j] = orR;
                3'd2:    res[j] = xorR;
                3'd3:    res[j] = ~andR;
                3'd4:    res[j] = ~orR;
                3'd5:    res[j] = ~xorR;
                3'd6:    res[j] = ops[j];
                default: res[j] = ~ops[j];
            endcase
        end
        return res;
    endfunction

    logic [WIDTH-1:0] qQ;
    logic [WIDTH-1:0] qD;
    logic             outValidQ;
    logic             outValidD;
    logic             sweepBusy;
    logic             sweepAccept;
    logic             beatAccept;

    // A sweep start wins over a beat presented in the same cycle.
    assign IN_READY   = !sweepBusy && (!outValidQ || OUT_READY);
    assign beatAccept = IN_VALID && IN_READY && !sweepAccept;

    always_comb begin
        qD        = qQ;
        outValidD = outValidQ;
        if (beatAccept) begin
            qD        = evalOp(MODE, A);
            outValidD = 1'b1;
        end else if (outValidQ && OUT_READY) begin
            outValidD = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            qQ        <= '0;
            outValidQ <= 1'b0;
        end else begin
            qQ        <= qD;
            outValidQ <= outValidD;
        end
    end

    assign Q         = qQ;
    assign OUT_VALID = outValidQ;

`ifdef LOGIC_GATE_SWEEP_EN

    typedef enum logic [1:0] {
        SW_IDLE = 2'd0,
        SW_RUN  = 2'd1,
        SW_DONE = 2'd2
    } sweepState_t;

    sweepState_t                 stateQ;
    sweepState_t                 stateD;
    logic [NUM_IN-1:0]           cntQ;
    logic [NUM_IN-1:0]           cntD;
    logic [2**NUM_IN-1:0]        ttQ;
    logic [2**NUM_IN-1:0]        ttD;
    logic [2:0]                  modeQ;
    logic [2:0]                  modeD;
    logic [NUM_IN*WIDTH-1:0]     sweepOps;
    logic [WIDTH-1:0]            sweepVec;
    logic                        unusedSweepVec;

    assign sweepAccept = SWEEP_START && (stateQ == SW_IDLE) && !outValidQ;

    // Operand k is flooded with CNT[k], so every result bit is identical and bit 0 suffices.
    always_comb begin
        sweepOps = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            sweepOps[k*WIDTH +: WIDTH] = {WIDTH{cntQ[k]}};
        end
    end

    assign sweepVec       = evalOp(modeQ, sweepOps);
    assign unusedSweepVec = ^sweepVec;

    always_comb begin
        stateD = stateQ;
        cntD   = cntQ;
        ttD    = ttQ;
        modeD  = modeQ;
        case (stateQ)
            SW_IDLE: begin
                if (sweepAccept) begin
                    stateD = SW_RUN;
                    modeD  = MODE;
                    ttD    = '0;
                    cntD   = '0;
                end
            end
            SW_RUN: begin
                ttD[cntQ] = sweepVec[0];
                cntD      = cntQ + NUM_IN'(1);
                if (cntQ == {NUM_IN{1'b1}}) begin
                    stateD = SW_DONE;
                end
            end
            SW_DONE: begin
                stateD = SW_IDLE;
            end
            default: begin
                stateD = SW_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stateQ <= SW_IDLE;
            cntQ   <= '0;
            ttQ    <= '0;
            modeQ  <= 3'd0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
            ttQ    <= ttD;
            modeQ  <= modeD;
        end
    end

    assign sweepBusy  = (stateQ != SW_IDLE);
    assign SWEEP_BUSY = sweepBusy;
    assign SWEEP_DONE = (stateQ == SW_DONE);
    assign TT         = ttQ;

`else

    logic unusedSweepStart;

    assign unusedSweepStart = SWEEP_START;
    assign sweepAccept      = 1'b0;
    assign sweepBusy        = 1'b0;
    assign SWEEP_BUSY       = 1'b0;
    assign SWEEP_DONE       = 1'b0;
    assign TT               = '0;

`endif

endmodule

// File: tb/tb_logic_gate_unit.sv
// Self-checking bench for logic_gate_unit: vector table, handshake corner cases, random stream vs. model.
// Sweep checks are compiled when LOGIC_GATE_SWEEP_EN is defined; otherwise the tied-off sweep ports are checked.
module tb_logic_gate_unit;

    logic       CLK;
    logic       RST_N;

    logic [2:0] modeA;
    logic [7:0] aA;
    logic       inValidA, inReadyA, outValidA, outReadyA;
    logic [3:0] qA;
    logic       sweepStartA, sweepBusyA, sweepDoneA;
    logic [3:0] ttA;

    logic [2:0] modeB;
    logic [2:0] aB;
    logic       inValidB, inReadyB, outValidB, outReadyB;
    logic [0:0] qB;
    logic       sweepStartB, sweepBusyB, sweepDoneB;
    logic [7:0] ttB;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0] mode;
        logic [7:0] a;
        logic [3:0] expQ;
    } vecA_t;

    vecA_t vecs [8];

    logic_gate_unit #(.WIDTH(4), .NUM_IN(2)) dutA (
        .CLK(CLK), .RST_N(RST_N), .MODE(modeA), .A(aA),
        .IN_VALID(inValidA), .IN_READY(inReadyA), .Q(qA), .OUT_VALID(outValidA),
        .OUT_READY(outReadyA), .SWEEP_START(sweepStartA), .SWEEP_BUSY(sweepBusyA),
        .SWEEP_DONE(sweepDoneA), .TT(ttA)
    );

    logic_gate_unit #(.WIDTH(1), .NUM_IN(3)) dutB (
        .CLK(CLK), .RST_N(RST_N), .MODE(modeB), .A(aB),
        .IN_VALID(inValidB), .IN_READY(inReadyB), .Q(qB), .OUT_VALID(outValidB),
        .OUT_READY(outReadyB), .SWEEP_START(sweepStartB), .SWEEP_BUSY(sweepBusyB),
        .SWEEP_DONE(sweepDoneB), .TT(ttB)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference: a gate result depends only on how many of the n inputs are 1.
    function automatic logic refBit(input logic [2:0] m, input int ones, input int n, input logic op0);
        case (m)
            3'd0:    return ones == n;
            3'd1:    return ones > 0;
            3'd2:    return (ones % 2) == 1;
            3'd3:    return ones != n;
            3'd4:    return ones == 0;
            3'd5:    return (ones % 2) == 0;
            3'd6:    return op0;
            default: return !op0;
        endcase
    endfunction

    function automatic logic [3:0] refVecA(input logic [2:0] m, input logic [7:0] a);
        logic [3:0] res;
        for (int j = 0; j < 4; j++) begin
            res[j] = refBit(m, int'(a[j]) + int'(a[4+j]), 2, a[j]);
        end
        return res;
    endfunction

    function automatic logic refVecB(input logic [2:0] m, input logic [2:0] a);
        return refBit(m, $countones(a), 3, a[0]);
    endfunction

    function automatic logic [7:0] refTT(input logic [2:0] m, input int n);
        logic [7:0] res;
        res = 8'h00;
        for (int i = 0; i < (1 << n); i++) begin
            res[i] = refBit(m, $countones(i), n, i[0]);
        end
        return res;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic stepCycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic [2:0] m, input logic [7:0] a, input logic iv, input logic ordy);
        modeA     = m;
        aA        = a;
        inValidA  = iv;
        outReadyA = ordy;
    endtask

`ifdef LOGIC_GATE_SWEEP_EN
    task automatic runSweep(input bit useB, input logic [2:0] m, input string name);
        int         runCycles;
        int         doneCycles;
        logic       busy;
        logic       done;
        logic [7:0] exp;
        exp = refTT(m, useB ? 3 : 2);
        if (useB) begin
            modeB       = m;
            sweepStartB = 1'b1;
        end else begin
            modeA       = m;
            sweepStartA = 1'b1;
            inValidA    = 1'b1;
            outReadyA   = 1'b1;
        end
        stepCycle();
        sweepStartA = 1'b0;
        sweepStartB = 1'b0;
        runCycles   = 0;
        doneCycles  = 0;
        for (int c = 0; c < 40; c++) begin
            busy = useB ? sweepBusyB : sweepBusyA;
            done = useB ? sweepDoneB : sweepDoneA;
            if (!busy) break;
            if (done) doneCycles++;
            else runCycles++;
            if (!useB) checkOutput({name, "_in_ready_busy"}, 32'(inReadyA), 32'(1'b0));
            modeA = 3'($urandom_range(0, 7));
            modeB = 3'($urandom_range(0, 7));
            stepCycle();
        end
        busy = useB ? sweepBusyB : sweepBusyA;
        checkOutput({name, "_busy_end"}, 32'(busy), 32'(1'b0));
        checkOutput({name, "_run_cycles"}, 32'(runCycles), 32'(useB ? 8 : 4));
        checkOutput({name, "_done_pulses"}, 32'(doneCycles), 32'(1));
        checkOutput({name, "_tt"}, useB ? 32'(ttB) : 32'(ttA), 32'(exp));
        checkOutput({name, "_no_beat"}, 32'(outValidA), 32'(1'b0));
        inValidA = 1'b0;
    endtask
`endif

    initial begin
        logic       mValidA, mValidB, mQB, expRdyA, expRdyB;
        logic [3:0] mQA;
        int         doneSeen;

        vecs[0] = '{3'd0, 8'hCA, 4'h8};
        vecs[1] = '{3'd1, 8'hCA, 4'hE};
        vecs[2] = '{3'd2, 8'hCA, 4'h6};
        vecs[3] = '{3'd3, 8'hCA, 4'h7};
        vecs[4] = '{3'd4, 8'hCA, 4'h1};
        vecs[5] = '{3'd5, 8'hCA, 4'h9};
        vecs[6] = '{3'd6, 8'hCA, 4'hA};
        vecs[7] = '{3'd7, 8'h3C, 4'h3};

        RST_N = 1'b0;
        applyStimulus(3'd0, 8'h00, 1'b0, 1'b0);
        modeB = 3'd0; aB = 3'd0; inValidB = 1'b0; outReadyB = 1'b0;
        sweepStartA = 1'b0; sweepStartB = 1'b0;
        #12;
        checkOutput("rst_q", 32'(qA), 32'(4'h0));
        checkOutput("rst_out_valid", 32'(outValidA), 32'(1'b0));
        checkOutput("rst_tt", 32'(ttA), 32'(4'h0));
        checkOutput("rst_busy", 32'(sweepBusyA), 32'(1'b0));
        checkOutput("rst_done", 32'(sweepDoneA), 32'(1'b0));
        checkOutput("rst_out_valid_b", 32'(outValidB), 32'(1'b0));
        RST_N = 1'b1;

        // Back-to-back beats with the consumer always ready; the first edge after reset must accept.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].mode, vecs[i].a, 1'b1, 1'b1);
            #1;
            checkOutput("vec_in_ready", 32'(inReadyA), 32'(1'b1));
            stepCycle();
            checkOutput("vec_q", 32'(qA), 32'(vecs[i].expQ));
            checkOutput("vec_out_valid", 32'(outValidA), 32'(1'b1));
        end
        inValidA = 1'b0;
        stepCycle();
        checkOutput("drain_out_valid", 32'(outValidA), 32'(1'b0));

        applyStimulus(3'd1, 8'h35, 1'b1, 1'b0);
        stepCycle();
        checkOutput("hold_first_q", 32'(qA), 32'(4'h7));
        checkOutput("hold_first_valid", 32'(outValidA), 32'(1'b1));
        for (int i = 0; i < 5; i++) begin
            applyStimulus(3'($urandom_range(0, 7)), 8'($urandom), 1'b1, 1'b0);
            #1;
            checkOutput("hold_in_ready", 32'(inReadyA), 32'(1'b0));
            stepCycle();
            checkOutput("hold_q", 32'(qA), 32'(4'h7));
            checkOutput("hold_valid", 32'(outValidA), 32'(1'b1));
        end
        applyStimulus(3'd2, 8'h35, 1'b1, 1'b1);
        #1;
        checkOutput("thru_in_ready", 32'(inReadyA), 32'(1'b1));
        stepCycle();
        checkOutput("thru_q", 32'(qA), 32'(4'h6));
        checkOutput("thru_valid", 32'(outValidA), 32'(1'b1));
        inValidA = 1'b0;
        stepCycle();
        checkOutput("thru_drain", 32'(outValidA), 32'(1'b0));

        mValidA = 1'b0;
        mValidB = 1'b0;
        mQA     = 4'h0;
        mQB     = 1'b0;
        for (int c = 0; c < 400; c++) begin
            applyStimulus(3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 3) != 0));
            modeB     = 3'($urandom_range(0, 7));
            aB        = 3'($urandom);
            inValidB  = 1'($urandom_range(0, 1));
            outReadyB = 1'($urandom_range(0, 3) != 0);
            #1;
            expRdyA = !mValidA || outReadyA;
            expRdyB = !mValidB || outReadyB;
            checkOutput("rand_in_ready_a", 32'(inReadyA), 32'(expRdyA));
            checkOutput("rand_in_ready_b", 32'(inReadyB), 32'(expRdyB));
            if (inValidA && expRdyA) begin
                mQA     = refVecA(modeA, aA);
                mValidA = 1'b1;
            end else if (mValidA && outReadyA) begin
                mValidA = 1'b0;
            end
            if (inValidB && expRdyB) begin
                mQB     = refVecB(modeB, aB);
                mValidB = 1'b1;
            end else if (mValidB && outReadyB) begin
                mValidB = 1'b0;
            end
            stepCycle();
            checkOutput("rand_valid_a", 32'(outValidA), 32'(mValidA));
            checkOutput("rand_valid_b", 32'(outValidB), 32'(mValidB));
            if (mValidA) checkOutput("rand_q_a", 32'(qA), 32'(mQA));
            if (mValidB) checkOutput("rand_q_b", 32'(qB), 32'(mQB));
        end
        inValidA = 1'b0; outReadyA = 1'b1;
        inValidB = 1'b0; outReadyB = 1'b1;
        stepCycle();
        checkOutput("rand_drain_a", 32'(outValidA), 32'(1'b0));
        checkOutput("rand_drain_b", 32'(outValidB), 32'(1'b0));

`ifdef LOGIC_GATE_SWEEP_EN
        runSweep(1'b0, 3'd1, "sweep_or2");

        // A start while a result is pending must be dropped and leave the table alone.
        applyStimulus(3'd0, 8'hFF, 1'b1, 1'b0);
        stepCycle();
        inValidA    = 1'b0;
        sweepStartA = 1'b1;
        stepCycle();
        sweepStartA = 1'b0;
        checkOutput("blocked_busy", 32'(sweepBusyA), 32'(1'b0));
        checkOutput("blocked_tt", 32'(ttA), 32'(refTT(3'd1, 2)));
        checkOutput("blocked_q", 32'(qA), 32'(4'hF));
        outReadyA = 1'b1;
        stepCycle();
        checkOutput("blocked_drain", 32'(outValidA), 32'(1'b0));

        runSweep(1'b1, 3'd2, "sweep_xor3");
        runSweep(1'b0, 3'd3, "sweep_nand2");

        modeA       = 3'd1;
        sweepStartA = 1'b1;
        stepCycle();
        sweepStartA = 1'b0;
        stepCycle();
        stepCycle();
        checkOutput("abort_tt_partial", 32'(ttA), 32'(refTT(3'd1, 2) & 8'h03));
        #2 RST_N = 1'b0;
        #1;
        checkOutput("abort_tt", 32'(ttA), 32'(4'h0));
        checkOutput("abort_busy", 32'(sweepBusyA), 32'(1'b0));
        checkOutput("abort_done", 32'(sweepDoneA), 32'(1'b0));
        #2 RST_N = 1'b1;
        doneSeen = 0;
        for (int c = 0; c < 12; c++) begin
            stepCycle();
            if (sweepDoneA) doneSeen++;
        end
        checkOutput("abort_no_done", 32'(doneSeen), 32'(0));
        checkOutput("abort_tt_after", 32'(ttA), 32'(4'h0));
        checkOutput("abort_busy_after", 32'(sweepBusyA), 32'(1'b0));
`else
        // Without the sweep engine a start request is inert and the beat goes through.
        applyStimulus(3'd0, 8'hCA, 1'b1, 1'b1);
        sweepStartA = 1'b1;
        sweepStartB = 1'b1;
        #1;
        checkOutput("nosweep_in_ready", 32'(inReadyA), 32'(1'b1));
        stepCycle();
        checkOutput("nosweep_busy", 32'(sweepBusyA), 32'(1'b0));
        checkOutput("nosweep_done", 32'(sweepDoneA), 32'(1'b0));
        checkOutput("nosweep_tt", 32'(ttA), 32'(4'h0));
        checkOutput("nosweep_tt_b", 32'(ttB), 32'(8'h00));
        checkOutput("nosweep_beat", 32'(outValidA), 32'(1'b1));
        checkOutput("nosweep_q", 32'(qA), 32'(4'h8));
        sweepStartA = 1'b0;
        sweepStartB = 1'b0;
        inValidA    = 1'b0;
        stepCycle();
        checkOutput("nosweep_drain", 32'(outValidA), 32'(1'b0));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/logic_gate_unit.md
LOGIC_GATE_UNIT -- requirements
Module: logic_gate_unit

Interface
REQ-001 SHALL have parameter: WIDTH, 4, bits per operand (1..32).
REQ-002 SHALL have parameter: NUM_IN, 2, operand count (2..8).
REQ-003 SHALL have port: CLK  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port: RST_N  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: MODE  input  3  op select: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 PASS op0, 7 NOT op0.
REQ-006 SHALL have port: A  input  NUM_IN*WIDTH  packed operands, operand k = A[k*WIDTH +: WIDTH].
REQ-007 SHALL have port: IN_VALID  input  1  operand beat valid.
REQ-008 SHALL have port: IN_READY  output  1  unit accepts beat.
REQ-009 SHALL have port: Q  output  WIDTH  registered bitwise result.
REQ-010 SHALL have port: OUT_VALID  output  1  Q valid.
REQ-011 SHALL have port: OUT_READY  input  1  consumer accepts Q.
REQ-012 SHALL have port: SWEEP_START  input  1  request truth-table sweep (gated by REQ-030).
REQ-013 SHALL have port: SWEEP_BUSY  output  1  sweep running.
REQ-014 SHALL have port: SWEEP_DONE  output  1  one-cycle pulse at sweep end.
REQ-015 SHALL have port: TT  output  2**NUM_IN  captured truth table (bit i = result for input combination i).

Function
REQ-016 SHALL compute each result bit j as MODE-selected reduction across bit j of all NUM_IN operands; modes 6/7 use operand 0 only.
REQ-017 SHALL accept a beat when IN_VALID && IN_READY, registering MODE/A result into Q and setting OUT_VALID next edge (latency 1).
REQ-018 SHALL drive IN_READY = !SWEEP_BUSY && (!OUT_VALID || OUT_READY), combinationally.
REQ-019 SHALL hold Q and OUT_VALID stable while OUT_VALID && !OUT_READY.
REQ-020 SHALL clear OUT_VALID on OUT_VALID && OUT_READY with no new beat accepted same cycle.
REQ-021 SHALL, on simultaneous output drain and input accept, load new Q with OUT_VALID staying 1 (full throughput, one beat per cycle).
REQ-022 SHALL ignore A/MODE changes when no beat is accepted.

Sweep FSM (states IDLE, RUN, DONE)
REQ-023 SHALL transition IDLE->RUN on accepted SWEEP_START, latching MODE, clearing TT and a NUM_IN-bit counter CNT to 0.
REQ-024 SHALL, in RUN, each cycle drive every bit of operand k to CNT[k] internally and write result bit 0 into TT[CNT].
REQ-025 SHALL increment CNT each RUN cycle; RUN->DONE after CNT = 2**NUM_IN-1 is written (exactly 2**NUM_IN RUN cycles, CNT wraps to 0).
REQ-026 SHALL go DONE->IDLE unconditionally after one cycle, SWEEP_DONE = 1 only in DONE.
REQ-027 SHALL assert SWEEP_BUSY in RUN and DONE.
REQ-028 SHALL hold TT stable outside RUN until next accepted SWEEP_START.
REQ-029 SHALL ignore MODE changes during RUN.
REQ-030 SHALL accept SWEEP_START only in IDLE with OUT_VALID = 0; otherwise ignore it (no queuing).
REQ-031 SHALL give SWEEP_START priority over IN_VALID in the same cycle: beat not accepted.

Reset
REQ-032 SHALL, on RST_N low, immediately force Q = 0, OUT_VALID = 0, TT = 0, CNT = 0, FSM = IDLE, SWEEP_BUSY = 0, SWEEP_DONE = 0.
REQ-033 SHALL abort a sweep or pending output on reset mid-operation, no partial TT retained.
REQ-034 SHALL release reset synchronously-safe: first accept possible on first rising edge with RST_N high.

Configuration
REQ-035 SHALL compile the sweep FSM, CNT, TT, SWEEP_* logic only when macro LOGIC_GATE_SWEEP_EN is defined.
REQ-036 SHALL, without LOGIC_GATE_SWEEP_EN, keep all ports, tie SWEEP_BUSY = 0, SWEEP_DONE = 0, TT = 0, ignore SWEEP_START, IN_READY = !OUT_VALID || OUT_READY.

Verification
REQ-037 SHALL test NUM_IN=2, WIDTH=1, MODE=1, SWEEP_START -> 4 RUN cycles, SWEEP_DONE pulse, TT = 4'b1110.
REQ-038 SHALL test NUM_IN=3, MODE=2 sweep -> TT = 8'b1001_0110; MODE=3 NUM_IN=2 -> TT = 4'b0111.
REQ-039 SHALL test WIDTH=4, MODE=0, A = {4'hC, 4'hA}, OUT_READY=1 -> Q = 4'h8, OUT_VALID next cycle.
REQ-040 SHALL test OUT_READY=0 with OUT_VALID=1 -> IN_READY=0, Q held over 5 cycles; OUT_READY=1 with IN_VALID -> new Q, OUT_VALID stays 1.
REQ-041 SHALL test RST_N low at RUN cycle 2 -> TT = 0, SWEEP_BUSY = 0 immediately, no SWEEP_DONE.
REQ-042 SHALL test SWEEP_START with OUT_VALID=1 -> ignored, SWEEP_BUSY stays 0, TT unchanged.
